// File: rtl/kyber_arith_pkg.sv
// Shared Kyber arithmetic constants and coefficient types,
// used by the basemul, NTT and Montgomery reduction blocks.
package kyber_arith_pkg;

    localparam int          KYBER_Q = 3329;
    localparam int          QINV    = 62209;
    localparam int          COEFF_W = 16;
    localparam int          RAW_W   = 32;
    localparam int unsigned STAGES  = 4;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic signed [RAW_W-1:0]   wide_t;

    // QINV taken as int16 (-3327), which is how the reduction consumes it
    localparam coeff_t QINV_S = coeff_t'(QINV);
    localparam wide_t  Q_W    = wide_t'(KYBER_Q);

endpackage

// File: rtl/montgomery_lane.sv
// One lane of the four-stage Montgomery reduction datapath; all stages
// shift together on en, control lives in the parent.
module montgomery_lane
    import kyber_arith_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    input  logic   en,
    input  logic   mode,
    input  coeff_t a,
    input  coeff_t b,
    input  wide_t  raw,
    output coeff_t result
);

    wide_t  x_s1;
    wide_t  x_s2;
    wide_t  x_s3;
    coeff_t t_s2;
    wide_t  u_s3;

    always_ff @(posedge clk) begin
        if (en) begin
            x_s1 <= mode ? raw : wide_t'(a) * wide_t'(b);
            x_s2 <= x_s1;
            t_s2 <= coeff_t'(x_s1 * wide_t'(QINV_S));
            x_s3 <= x_s2;
            u_s3 <= wide_t'(t_s2) * Q_W;
        end
    end

    // Low 16 bits of x - u are zero by construction, so only the upper half is kept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            result <= '0;
        else if (en)
            result <= coeff_t'((x_s3 - u_s3) >>> 16);
    end

endmodule

// File: rtl/kyber_montgomery_reduce_pipe.sv
// Multi-lane pipelined Montgomery reduction with valid/ready streaming;
// owns the valid/tag chain, flush and backpressure for all lanes.
module kyber_montgomery_reduce_pipe
    import kyber_arith_pkg::*;
#(
    parameter int LANES = 2,
    parameter int TAG_W = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_mode,
    input  logic [LANES*COEFF_W-1:0] in_a,
    input  logic [LANES*COEFF_W-1:0] in_b,
    input  logic [LANES*RAW_W-1:0]   in_raw,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*COEFF_W-1:0] out_coeffs,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    logic [STAGES-1:0] stage_valid;
    logic [TAG_W-1:0]  stage_tag [STAGES];
    logic              advance;

    assign advance   = !stage_valid[STAGES-1] || out_ready;
    assign in_ready  = advance && !flush;
    assign out_valid = stage_valid[STAGES-1];
    assign out_tag   = stage_tag[STAGES-1];
    assign busy      = |stage_valid;

    // Flush wins over accept and output transfer; lane data may still shift but is unqualified
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_valid <= '0;
            for (int unsigned s = 0; s < STAGES; s++)
                stage_tag[s] <= '0;
        end else if (flush) begin
            stage_valid <= '0;
        end else if (advance) begin
            stage_valid <= {stage_valid[STAGES-2:0], in_valid};
            stage_tag[0] <= in_tag;
            for (int unsigned s = 1; s < STAGES; s++)
                stage_tag[s] <= stage_tag[s-1];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        montgomery_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (advance),
            .mode    (in_mode),
            .a       (in_a[i*COEFF_W +: COEFF_W]),
            .b       (in_b[i*COEFF_W +: COEFF_W]),
            .raw     (in_raw[i*RAW_W +: RAW_W]),
            .result  (out_coeffs[i*COEFF_W +: COEFF_W])
        );
    end

endmodule
